// File: rtl/dm_cache_fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dm_cache_fsm_pkg
//  Description : Shared types and constants for the direct-mapped cache.
//  Revision    : 1.0
// ============================================================================
package dm_cache_fsm_pkg;

    localparam int TAGMSB    = 32;
    localparam int TAGLSB    = 14;
    localparam int INDEX_LSB = 4;
    localparam int INDEX_W   = 10;

    typedef struct packed {
        logic                valid;
        logic                dirty;
        logic [TAGMSB:TAGLSB] tag;
    } cache_tag_type;

    typedef struct packed {
        logic [INDEX_W-1:0] index;
        logic               we;
    } cache_req_type;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw;
        logic        valid;
    } cpu_req_type;

    typedef struct packed {
        logic [31:0] data;
        logic        ready;
    } cpu_result_type;

    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         rw;
        logic         valid;
    } mem_req_type;

    typedef struct packed {
        logic [31:0] data;
        logic        ready;
    } mem_data_type;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        COMPARE    = 2'd1,
        WRITE_BACK = 2'd2,
        ALLOCATE   = 2'd3
    } cache_state_type;

    // Stored tag carries a constant-zero top bit above the address tag bits.
    function automatic logic [TAGMSB:TAGLSB] addr_tag(input logic [31:TAGLSB] hi);
        return {1'b0, hi};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_cache_ram.sv
`default_nettype none
// ============================================================================
//  Module      : dm_cache_ram
//  Description : Tag/data storage with flop-based valid/dirty bits.
//  Revision    : 1.0
// ============================================================================
module dm_cache_ram
    import dm_cache_fsm_pkg::*;
#(
    parameter int NUM_LINES = 1024
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  cache_req_type i_req,
    input  cache_tag_type i_tag_wr,
    input  logic [31:0]   i_data_wr,
    output cache_tag_type o_tag_rd,
    output logic [31:0]   o_data_rd
);

    logic [TAGMSB:TAGLSB] r_tag_mem  [NUM_LINES];
    logic [31:0]          r_data_mem [NUM_LINES];
    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;

    always_ff @(posedge clk) begin
        if (i_req.we) begin
            r_tag_mem[i_req.index]  <= i_tag_wr.tag;
            r_data_mem[i_req.index] <= i_data_wr;
        end
    end

    // Valid/dirty live in flops so a single reset cycle invalidates every line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_req.we) begin
            r_valid[i_req.index] <= i_tag_wr.valid;
            r_dirty[i_req.index] <= i_tag_wr.dirty;
        end
    end

    always_comb begin
        o_tag_rd.valid = r_valid[i_req.index];
        o_tag_rd.dirty = r_dirty[i_req.index];
        o_tag_rd.tag   = r_tag_mem[i_req.index];
        o_data_rd      = r_data_mem[i_req.index];
    end

endmodule
`default_nettype wire

// File: rtl/dm_cache_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : dm_cache_fsm
//  Description : Direct-mapped write-back/write-allocate cache controller.
//  Revision    : 1.0
// ============================================================================
module dm_cache_fsm
    import dm_cache_fsm_pkg::*;
#(
    parameter int NUM_LINES = 1024
)
(
    input  logic           clk,
    input  logic           rst_n,
    input  cpu_req_type    cpu_req,
    input  mem_data_type   mem_data,
    output mem_req_type    mem_req,
    output cpu_result_type cpu_res
);

    cache_state_type      r_state;
    cpu_req_type          r_req;

    logic [INDEX_W-1:0]   w_index;
    logic [TAGMSB:TAGLSB] w_tag;
    logic                 w_hit;
    cache_req_type        w_ram_req;
    cache_tag_type        w_tag_wr;
    logic [31:0]          w_data_wr;
    cache_tag_type        w_tag_rd;
    logic [31:0]          w_data_rd;
    mem_req_type          w_fill_req;
    logic                 w_unused;

    assign w_index = r_req.addr[INDEX_LSB +: INDEX_W];
    assign w_tag   = addr_tag(r_req.addr[31:TAGLSB]);
    assign w_hit   = w_tag_rd.valid && (w_tag_rd.tag == w_tag);

    assign w_unused = ^{r_req.addr[INDEX_LSB-1:0], r_req.valid, w_tag_rd.tag[TAGMSB]};

    always_comb begin
        w_fill_req       = '0;
        w_fill_req.addr  = {r_req.addr[31:INDEX_LSB], 4'h0};
        w_fill_req.rw    = 1'b0;
        w_fill_req.valid = 1'b1;
    end

    // Storage writes and the CPU response are decided in the same cycle as the lookup.
    always_comb begin
        w_ram_req.index = w_index;
        w_ram_req.we    = 1'b0;
        w_tag_wr        = '0;
        w_data_wr       = '0;
        cpu_res         = '0;
        case (r_state)
            COMPARE: begin
                if (w_hit) begin
                    cpu_res.ready = 1'b1;
                    cpu_res.data  = r_req.rw ? r_req.data : w_data_rd;
                    if (r_req.rw) begin
                        w_ram_req.we   = rst_n;
                        w_tag_wr.valid = 1'b1;
                        w_tag_wr.dirty = 1'b1;
                        w_tag_wr.tag   = w_tag;
                        w_data_wr      = r_req.data;
                    end
                end
            end
            ALLOCATE: begin
                if (mem_data.ready) begin
                    w_ram_req.we   = rst_n;
                    w_tag_wr.valid = 1'b1;
                    w_tag_wr.dirty = 1'b0;
                    w_tag_wr.tag   = w_tag;
                    w_data_wr      = mem_data.data;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_req   <= '0;
            mem_req <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cpu_req.valid) begin
                        r_req   <= cpu_req;
                        r_state <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (w_hit) begin
                        r_state <= IDLE;
                    end else if (w_tag_rd.valid && w_tag_rd.dirty) begin
                        mem_req.addr  <= {w_tag_rd.tag[TAGMSB-1:TAGLSB], w_index, 4'h0};
                        mem_req.data  <= {96'b0, w_data_rd};
                        mem_req.rw    <= 1'b1;
                        mem_req.valid <= 1'b1;
                        r_state       <= WRITE_BACK;
                    end else begin
                        mem_req <= w_fill_req;
                        r_state <= ALLOCATE;
                    end
                end
                WRITE_BACK: begin
                    if (mem_data.ready) begin
                        mem_req <= w_fill_req;
                        r_state <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (mem_data.ready) begin
                        mem_req.valid <= 1'b0;
                        r_state       <= COMPARE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    dm_cache_ram #(
        .NUM_LINES (NUM_LINES)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (w_ram_req),
        .i_tag_wr  (w_tag_wr),
        .i_data_wr (w_data_wr),
        .o_tag_rd  (w_tag_rd),
        .o_data_rd (w_data_rd)
    );

endmodule
`default_nettype wire
